mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with fixed response latency,
// byte-enabled stores and misaligned/out-of-range error reporting.
module mem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam bit          LAT_ONE = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_nxt_s;
    logic          enter_resp_s;
    logic          accept_s;

    logic          wr_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    be_r;

    logic          acc_write_s;
    logic [31:0]   acc_addr_s;
    logic [31:0]   acc_wdata_s;
    logic [3:0]    acc_be_s;
    logic          acc_err_s;
    logic [AW-1:0] acc_idx_s;
    logic          mem_we_s;

    logic [31:0]   rdata_r;
    logic          err_r;
    logic [31:0]   mem [DEPTH];

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign accept_s = (state_r == ST_IDLE) && bus.req_valid;

    // State and latency counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; enter_resp_s marks the edge where memory is accessed.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (LAT_ONE) begin
                        state_nxt_s  = ST_RESP;
                        cnt_nxt_s    = 4'd0;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s  = ST_WAIT;
                        cnt_nxt_s    = LAT_M1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s  = ST_RESP;
                    cnt_nxt_s    = 4'd0;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_nxt_s    = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Request capture on acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            be_r    <= 4'd0;
        end else if (accept_s) begin
            wr_r    <= bus.req_write;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            be_r    <= bus.req_be;
        end
    end

    // With LATENCY=1 the access happens on the accepting edge, so use live inputs.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_write_s = bus.req_write;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
            acc_be_s    = bus.req_be;
        end else begin
            acc_write_s = wr_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_be_s    = be_r;
        end
    end

    assign acc_err_s = addr_err(acc_addr_s);
    assign acc_idx_s = acc_addr_s[AW+1:2];
    assign mem_we_s  = enter_resp_s && acc_write_s && !acc_err_s;

    // Storage array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[acc_idx_s] <= merge_bytes(mem[acc_idx_s], acc_wdata_s, acc_be_s);
        end
    end

    // Response data/error registers, loaded once on entry to RESP and held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            rdata_r <= (acc_write_s || acc_err_s) ? 32'd0 : mem[acc_idx_s];
            err_r   <= acc_err_s;
        end
    end

    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.rsp_valid = (state_r == ST_RESP);
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = err_r;
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 and LATENCY=1 builds).
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_responder_if b2 ();
    mem_responder_if b1 ();

    mem_responder #(.DEPTH(64), .LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd,
                         output logic er, output int lat);
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_write = w; b2.req_addr = a;
        b2.req_wdata = d; b2.req_be = be; b2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        b2.req_valid = 1'b0; b2.req_write = ~w; b2.req_addr = 32'h0000_0004;
        b2.req_wdata = 32'h5555_AAAA; b2.req_be = 4'hF;
        lat = 1;
        while (!b2.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = b2.rsp_rdata;
        er = b2.rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = 32'd0;
        b2.req_wdata = 32'd0; b2.req_be = 4'd0; b2.rsp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = 32'd0;
        b1.req_wdata = 32'd0; b1.req_be = 4'd0; b1.rsp_ready = 1'b0;
        #1;
        checks++; if (b2.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", b2.rsp_valid); end
        checks++; if (b2.rsp_rdata !== 32'd0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", b2.rsp_rdata); end
        checks++; if (b2.rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", b2.rsp_err); end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (b2.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", b2.req_ready); end
        checks++; if (b1.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready_l1 got=%b exp=1", b1.req_ready); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL st_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL st_err got=%b exp=0", er); end
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL st_rdata got=%h exp=0", rd); end
        issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ld_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL ld_err got=%b exp=0", er); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er, lat);
        issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, rd, er, lat);
        issue(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
        issue(1'b1, 32'h20, 32'h0000_0000, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL be0_err got=%b exp=0", er); end
        issue(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL be0_noop got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        issue(1'b0, 32'h22, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL mis_ld_err got=%b exp=1", er); end
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL mis_ld_rdata got=%h exp=0", rd); end
        issue(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_st_err got=%b exp=1", er); end
        issue(1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL mis_st_err got=%b exp=1", er); end
        issue(1'b0, 32'h8000_0000, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL hi_ld_err got=%b exp=1", er); end
        issue(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL err_nowrite got=%h exp=cafef00d", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL ld0_err got=%b exp=0", er); end
        issue(1'b1, 32'hFC, 32'h5A5A_5A5A, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL top_st_err got=%b exp=0", er); end
        issue(1'b0, 32'hFC, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h5A5A_5A5A) begin failures++; $display("FAIL top_ld got=%h exp=5a5a5a5a", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_write = 1'b0; b2.req_addr = 32'h10; b2.req_be = 4'h0; b2.rsp_ready = 1'b0;
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
        checks++; if (b2.req_ready !== 1'b0) begin failures++; $display("FAIL bp_wait_ready got=%b exp=0", b2.req_ready); end
        checks++; if (b2.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_wait_valid got=%b exp=0", b2.rsp_valid); end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (b2.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, b2.rsp_valid); end
            checks++; if (b2.rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_rdata[%0d] got=%h exp=deadbeef", i, b2.rsp_rdata); end
            checks++; if (b2.req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, b2.req_ready); end
            @(negedge clk);
            b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 32'h10;
            b2.req_wdata = 32'h0BAD_0000 + 32'(i); b2.req_be = 4'hF;
            @(posedge clk); #1;
        end
        @(negedge clk); b2.rsp_ready = 1'b1; b2.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (b2.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", b2.rsp_valid); end
        checks++; if (b2.req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", b2.req_ready); end
        issue(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_ignored got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 32'h30;
        b2.req_wdata = 32'h1234_5678; b2.req_be = 4'hF; b2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        b2.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (b2.rsp_valid !== 1'b0) begin failures++; $display("FAIL rstw_valid got=%b exp=0", b2.rsp_valid); end
        checks++; if (b2.req_ready !== 1'b1) begin failures++; $display("FAIL rstw_ready got=%b exp=1", b2.req_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        issue(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstw_nowrite got=%h exp=0", rd); end
        // Reset while holding a load response in RESP.
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_write = 1'b0; b2.req_addr = 32'h10; b2.rsp_ready = 1'b0;
        @(posedge clk); #1; b2.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (b2.rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rstr_pre got=%h exp=deadbeef", b2.rsp_rdata); end
        rst_n = 1'b0;
        #1;
        checks++; if (b2.rsp_valid !== 1'b0) begin failures++; $display("FAIL rstr_valid got=%b exp=0", b2.rsp_valid); end
        checks++; if (b2.rsp_rdata !== 32'd0) begin failures++; $display("FAIL rstr_rdata got=%h exp=0", b2.rsp_rdata); end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1; b2.rsp_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic        w_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] a_v   [4] = '{32'h40, 32'h40, 32'h44, 32'h44};
        logic [31:0] d_v   [4] = '{32'h0000_00A1, 32'h0, 32'h0000_00B2, 32'h0};
        logic [31:0] exp_v [4] = '{32'h0, 32'h0000_00A1, 32'h0, 32'h0000_00B2};
        @(negedge clk);
        b1.rsp_ready = 1'b1; b1.req_valid = 1'b1; b1.req_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            b1.req_write = w_v[k]; b1.req_addr = a_v[k]; b1.req_wdata = d_v[k];
            @(posedge clk); #1;
            checks++; if (b1.rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, b1.rsp_valid); end
            checks++; if (b1.rsp_rdata !== exp_v[k]) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", k, b1.rsp_rdata, exp_v[k]); end
            @(negedge clk);
            b1.req_write = 1'b1; b1.req_addr = a_v[k]; b1.req_wdata = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            checks++; if (b1.rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap[%0d] got=%b exp=0", k, b1.rsp_valid); end
            checks++; if (b1.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, b1.req_ready); end
            @(negedge clk);
        end
        b1.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
